input_debouncer: RTL and testbench

INPUT_DEBOUNCER -- requirements
Module: input_debouncer

---
 rtl/input_debouncer_pkg.sv | 14 +
 rtl/input_debouncer_sync.sv | 24 ++
 rtl/input_debouncer.sv | 115 +++++++++++
 tb/tb_input_debouncer.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/input_debouncer_pkg.sv
// Shared types and constants for the input_debouncer block.
// Optional glitch counter is enabled by defining INPUT_DEBOUNCER_GLITCH_CNT_EN.
package input_debouncer_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'b00,
        QUAL_HI   = 2'b01,
        STABLE_HI = 2'b10,
        QUAL_LO   = 2'b11
    } deb_state_t;

    localparam int unsigned GLITCH_CNT_W = 8;

endpackage : input_debouncer_pkg

// File: rtl/input_debouncer_sync.sv
// sync_ff_chain: generic multi-flop synchronizer for asynchronous single-bit inputs.
// Reusable by any input stage; q is the output of the last flop.
module sync_ff_chain #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_r;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[STAGES-2:0], d};
        end
    end

    assign q = sync_r[STAGES-1];

endmodule : sync_ff_chain

// File: rtl/input_debouncer.sv
// input_debouncer: synchronizes and debounces a bouncing asynchronous input.
// Define INPUT_DEBOUNCER_GLITCH_CNT_EN to add the glitch_cnt / glitch_clr ports and counter.
module input_debouncer
    import input_debouncer_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 16
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    data_raw,
    output logic                    data_out,
    output logic                    busy
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
    ,
    output logic [GLITCH_CNT_W-1:0] glitch_cnt,
    input  logic                    glitch_clr
`endif
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    deb_state_t       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             sync_q;

    sync_ff_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (data_raw),
        .q      (sync_q)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            STABLE_LO: begin
                if (sync_q) begin
                    state_d = QUAL_HI;
                    count_d = '0;
                end
            end
            QUAL_HI: begin
                if (!sync_q) begin
                    state_d = STABLE_LO;
                    count_d = '0;
                end else if (count_q == CNT_LAST) begin
                    state_d = STABLE_HI;
                    count_d = '0;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            STABLE_HI: begin
                if (!sync_q) begin
                    state_d = QUAL_LO;
                    count_d = '0;
                end
            end
            QUAL_LO: begin
                if (sync_q) begin
                    state_d = STABLE_HI;
                    count_d = '0;
                end else if (count_q == CNT_LAST) begin
                    state_d = STABLE_LO;
                    count_d = '0;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = STABLE_LO;
                count_d = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet aligned with state_q.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= STABLE_LO;
            count_q  <= '0;
            data_out <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            data_out <= (state_d == STABLE_HI) || (state_d == QUAL_LO);
            busy     <= (state_d == QUAL_HI) || (state_d == QUAL_LO);
        end
    end

`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
    logic glitch_evt;

    assign glitch_evt = ((state_q == QUAL_HI) && !sync_q) ||
                        ((state_q == QUAL_LO) &&  sync_q);

    // Clear takes priority over a coincident glitch; the count saturates at all-ones.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            glitch_cnt <= '0;
        end else if (glitch_clr) begin
            glitch_cnt <= '0;
        end else if (glitch_evt && (glitch_cnt != '1)) begin
            glitch_cnt <= glitch_cnt + GLITCH_CNT_W'(1);
        end
    end
`endif

endmodule : input_debouncer

// File: tb/tb_input_debouncer.sv
// Self-checking bench for input_debouncer: two instances (DEBOUNCE_CYCLES 16 and 4)
// checked every cycle against a run-length reference model.
module tb_input_debouncer;

    localparam int unsigned S  = 2;
    localparam int unsigned DA = 16;
    localparam int unsigned DB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetn;
    logic raw_a, raw_b;
    logic out_a, out_b, busy_a, busy_b;
    logic clr_a, clr_b;
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
    logic [7:0] gc_a, gc_b;
`endif

    input_debouncer #(
        .SYNC_STAGES     (S),
        .DEBOUNCE_CYCLES (DA),
        .CNT_W           (16)
    ) dut_a (
        .clk        (clk),
        .resetn     (resetn),
        .data_raw   (raw_a),
        .data_out   (out_a),
        .busy       (busy_a)
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
        ,
        .glitch_cnt (gc_a),
        .glitch_clr (clr_a)
`endif
    );

    input_debouncer #(
        .SYNC_STAGES     (S),
        .DEBOUNCE_CYCLES (DB),
        .CNT_W           (4)
    ) dut_b (
        .clk        (clk),
        .resetn     (resetn),
        .data_raw   (raw_b),
        .data_out   (out_b),
        .busy       (busy_b)
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
        ,
        .glitch_cnt (gc_b),
        .glitch_clr (clr_b)
`endif
    );

    // Reference model: a new level is accepted once the synchronized input has
    // disagreed with the output for DEBOUNCE_CYCLES+1 consecutive samples
    // (the detecting sample plus DEBOUNCE_CYCLES qualifying ones).
    int unsigned deb[2];
    bit          hist[2][$];
    bit          m_out[2];
    int unsigned m_run[2];
    int unsigned m_gl[2];

    int unsigned tests = 0;
    int unsigned fails = 0;

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            hist[i].delete();
            for (int k = 0; k < int'(S); k++) hist[i].push_back(1'b0);
            m_out[i] = 1'b0;
            m_run[i] = 0;
            m_gl[i]  = 0;
        end
    endfunction

    function automatic void model_edge(input int i, input bit raw, input bit clr);
        bit s;
        bit evt;
        s   = hist[i].pop_front();
        hist[i].push_back(raw);
        evt = 1'b0;
        if (s != m_out[i]) begin
            m_run[i]++;
            if (m_run[i] == deb[i] + 1) begin
                m_out[i] = ~m_out[i];
                m_run[i] = 0;
            end
        end else if (m_run[i] != 0) begin
            evt      = 1'b1;
            m_run[i] = 0;
        end
        if (clr) m_gl[i] = 0;
        else if (evt && m_gl[i] < 255) m_gl[i]++;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        check("out_a",  {7'd0, out_a},  {7'd0, m_out[0]});
        check("busy_a", {7'd0, busy_a}, {7'd0, m_run[0] != 0});
        check("out_b",  {7'd0, out_b},  {7'd0, m_out[1]});
        check("busy_b", {7'd0, busy_b}, {7'd0, m_run[1] != 0});
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
        check("glitch_cnt_a", gc_a, m_gl[0][7:0]);
        check("glitch_cnt_b", gc_b, m_gl[1][7:0]);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        if (resetn) begin
            model_edge(0, raw_a, clr_a);
            model_edge(1, raw_b, clr_b);
        end
        #1;
        check_all();
    endtask

    // Counts edges after the sampling edge until out_a reaches lvl; also counts busy cycles.
    task automatic measure_a(input logic lvl, output int unsigned lat, output int unsigned bcnt);
        int unsigned n;
        n    = 0;
        bcnt = 0;
        do begin
            tick();
            n++;
            if (busy_a) bcnt++;
        end while (out_a !== lvl && n < 60);
        lat = n - 1;
    endtask

    initial begin
        int unsigned lat, bcnt, n;
        logic        maxo;
        int unsigned len_a, len_b;

        deb[0] = DA;
        deb[1] = DB;
        resetn = 1'b0;
        raw_a  = 1'b1;
        raw_b  = 1'b1;
        clr_a  = 1'b0;
        clr_b  = 1'b0;
        model_reset();
        #1;
        check_all();
        repeat (4) tick();
        check("reset_out_a", {7'd0, out_a}, 8'd0);
        raw_a  = 1'b0;
        raw_b  = 1'b0;
        resetn = 1'b1;
        repeat (5) tick();

        // Clean rise and fall on the default instance.
        raw_a = 1'b1;
        measure_a(1'b1, lat, bcnt);
        check("rise_latency", lat[7:0], 8'(S + DA));
        check("rise_busy_cycles", bcnt[7:0], 8'(DA));
        repeat (5) tick();
        raw_a = 1'b0;
        measure_a(1'b0, lat, bcnt);
        check("fall_latency", lat[7:0], 8'(S + DA));
        check("fall_busy_cycles", bcnt[7:0], 8'(DA));
        repeat (5) tick();

        // Reset asserted at qualification cycle 10 aborts without a glitch.
        raw_a = 1'b1;
        n = 0;
        while (!busy_a && n < 10) begin
            tick();
            n++;
        end
        check("qual_started", {7'd0, busy_a}, 8'd1);
        repeat (10) tick();
        resetn = 1'b0;
        model_reset();
        #1;
        check_all();
        check("midqual_reset_busy", {7'd0, busy_a}, 8'd0);
        repeat (2) tick();
        resetn = 1'b1;
        measure_a(1'b1, lat, bcnt);
        check("post_reset_latency", lat[7:0], 8'(S + DA));

        raw_a = 1'b0;
        repeat (25) tick();

        // Bounce: 3-cycle toggles for 40 cycles, then hold high.
        maxo = 1'b0;
        for (int c = 0; c < 40; c++) begin
            raw_a = ((c / 3) % 2 == 0);
            tick();
            maxo = maxo | out_a;
        end
        check("bounce_out_low", {7'd0, maxo}, 8'd0);
        raw_a = 1'b1;
        measure_a(1'b1, lat, bcnt);
        check("bounce_settle_latency", lat[7:0], 8'(S + DA));
        repeat (3) tick();

        // Boundary on DEBOUNCE_CYCLES=4: pulse widths counted as qualifying
        // cycles after the detecting one (raw held one cycle longer).
        maxo  = 1'b0;
        raw_b = 1'b1;
        repeat (DB) begin
            tick();
            maxo = maxo | out_b;
        end
        raw_b = 1'b0;
        repeat (12) begin
            tick();
            maxo = maxo | out_b;
        end
        check("pulse_3_no_change", {7'd0, maxo}, 8'd0);
        maxo  = 1'b0;
        raw_b = 1'b1;
        repeat (DB + 1) begin
            tick();
            maxo = maxo | out_b;
        end
        raw_b = 1'b0;
        repeat (12) begin
            tick();
            maxo = maxo | out_b;
        end
        check("pulse_4_accepted", {7'd0, maxo}, 8'd1);
        repeat (12) tick();

        // Randomized bursts on both instances, model-checked every cycle.
        len_a = 0;
        len_b = 0;
        for (int c = 0; c < 1500; c++) begin
            if (len_a == 0) begin
                raw_a = ~raw_a;
                len_a = $urandom_range(1, 24);
            end
            if (len_b == 0) begin
                raw_b = ~raw_b;
                len_b = $urandom_range(1, 8);
            end
            len_a--;
            len_b--;
            clr_a = ($urandom_range(0, 99) == 0);
            clr_b = ($urandom_range(0, 99) == 0);
            tick();
        end
        clr_a = 1'b0;
        clr_b = 1'b0;
        raw_a = 1'b0;
        raw_b = 1'b0;
        repeat (40) tick();

`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
        // Saturation after 300 forced glitches, then clear coincident with a glitch.
        repeat (300) begin
            raw_b = 1'b1;
            repeat (2) tick();
            raw_b = 1'b0;
            repeat (3) tick();
        end
        check("glitch_saturate", gc_b, 8'd255);
        raw_b = 1'b1;
        repeat (2) tick();
        raw_b = 1'b0;
        repeat (2) tick();
        clr_b = 1'b1;
        tick();
        clr_b = 1'b0;
        tick();
        check("glitch_clr_wins", gc_b, 8'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_input_debouncer
